fifo_drain_packer: RTL
======================

Name: fifo_drain_packer

Overview:
Read-side consumer placed directly downstream of the team's synchronous FIFO (4-bit words, registered read data, underflow flag). It issues single-cycle pops and checks the FIFO's underflow response. It packs PACK_COUNT successful words LSB-first into one wide word and presents that word on a valid/ready output. Failed pops trigger a fixed back-off before the next retry.

Parameters:
DATA_WIDTH, 4, width of one FIFO word.
PACK_COUNT, 2, FIFO words per output word (>=2); OUT_WIDTH = DATA_WIDTH*PACK_COUNT.
BACKOFF_CYCLES, 2, idle cycles after a failed pop before retry (>=1).
CNT_WIDTH, 8, width of saturating underflow counter.

Ports:
clk  in  1  rising-edge clock shared with the FIFO.
rst  in  1  synchronous active-low reset, sampled on posedge clk.
fifo_rd  out  1  pop request to FIFO, one-cycle pulse.
fifo_data  in  DATA_WIDTH  FIFO registered read data; valid in the cycle after fifo_rd.
fifo_underflow  in  1  FIFO empty response; valid in the cycle after fifo_rd.
flush  in  1  discard partial pack.
out_data  out  OUT_WIDTH  packed word.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accept.
pack_cnt  out  $clog2(PACK_COUNT)+1  words held in current partial pack.
underflow_cnt  out  CNT_WIDTH  saturating count of failed pops.

Behaviour:
- Reset (rst==0 at posedge): state=POP, fifo_rd=0, out_valid=0, out_data=0, pack_cnt=0, underflow_cnt=0, backoff counter=0. Reset mid-operation drops the partial pack and any held output. An outstanding pop response is ignored.
- Pop contract: every fifo_rd pulse is followed by exactly one CHECK cycle. fifo_rd is never asserted in two consecutive cycles. Peak rate is one FIFO word per 2 cycles.
- POP: fifo_rd=1, then go to CHECK.
- CHECK: fifo_rd=0. Sample fifo_underflow.
  - underflow=0: write fifo_data into slot pack_cnt, bits [pack_cnt*DATA_WIDTH +: DATA_WIDTH]. pack_cnt+1.
    - If this was slot PACK_COUNT-1: register the full word into out_data, set out_valid=1, set pack_cnt=0, go to HOLD.
    - Otherwise go to POP.
  - underflow=1: discard fifo_data. underflow_cnt+1, saturating at all-ones. Load backoff counter with BACKOFF_CYCLES, go to BACKOFF.
- BACKOFF: decrement the counter each cycle. Go to POP on the cycle the counter reaches 1, which gives exactly BACKOFF_CYCLES non-pop cycles.
- HOLD: out_valid=1 and out_data stable until out_ready=1 is seen at a posedge. On that edge out_valid clears and the state goes to POP. No pops are issued in HOLD (no skid buffer).
- out_ready is ignored while out_valid=0. out_valid never drops without a handshake, except at reset.
- flush (sampled at posedge, reset has priority):
  - POP/BACKOFF: pack_cnt=0, partial slots cleared, state unchanged.
  - CHECK: the returning word is discarded regardless of underflow. pack_cnt=0. Go to POP, or BACKOFF if underflow=1; underflow_cnt still counts a failed pop.
  - HOLD: flush is ignored; the held word is not retracted.
- Unfilled slots of the pack register are 0. out_data is updated only on the HOLD transition.

Optional Feature:
FIFO_DRAIN_PARITY_EN: when defined, adds output port out_parity (1 bit). It is the even parity (XOR reduction) of out_data, registered with out_data, valid while out_valid=1, and 0 after reset. When undefined the port and its logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg holds:
  - state enum drain_state_t {POP, CHECK, BACKOFF, HOLD};
  - default DATA_WIDTH/PACK_COUNT constants;
  - function for OUT_WIDTH.
- One natural sub-module, drain_backoff_timer: load value, decrement, done pulse, synchronous active-low rst. The FSM and pack register stay in the top.

Test Plan:
- FIFO preloaded with 0x3, 0xA, out_ready=1 → fifo_rd pulses at cycles 1 and 3 after reset release; out_data=0xA3 with out_valid=1 for one cycle; underflow_cnt=0.
- Empty FIFO for 10 cycles (BACKOFF_CYCLES=2) → fifo_rd every 4th cycle; underflow_cnt increments once per pop; out_valid stays 0. With CNT_WIDTH=2, underflow_cnt saturates at 3.
- Words 0x1, 0x2, 0x3, 0x4 with out_ready=0 → out_data=0x21 held and fifo_rd=0 for 5 cycles. Raise out_ready → next output 0x43.
- 0x5 popped, then flush → pack_cnt=0. Then 0x6, 0x7 → out_data=0x76, with 0x5 absent.
- rst=0 asserted during CHECK with pack_cnt=1 → next cycle all outputs 0. After release, the first pack comes from fresh data only.
- FIFO_DRAIN_PARITY_EN defined, words 0x1, 0x2 → out_data=0x21, out_parity=0. Words 0x1, 0x3 → out_data=0x31, out_parity=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side drain packer.
package fifo_pkg;

    // Drain FSM: issue a pop, check the response, back off after a miss, hold a full word.
    typedef enum logic [1:0] {
        POP     = 2'd0,
        CHECK   = 2'd1,
        BACKOFF = 2'd2,
        HOLD    = 2'd3
    } drain_state_t;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_PACK_COUNT = 2;

    // Width of one packed output word.
    function automatic int out_width(input int data_width, input int pack_count);
        return data_width * pack_count;
    endfunction

    // Width of the partial-pack word counter (must be able to hold 0..pack_count).
    function automatic int pack_cnt_width(input int pack_count);
        return $clog2(pack_count) + 1;
    endfunction

endpackage

// File: rtl/fifo_drain_packer_if.sv
// FIFO read side plus packed valid/ready output of the drain packer.
// Optional macro FIFO_DRAIN_PARITY_EN adds out_parity to the bundle.
interface fifo_drain_packer_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int PACK_COUNT = fifo_pkg::DEFAULT_PACK_COUNT,
    parameter int CNT_WIDTH  = 8
);
    import fifo_pkg::*;

    localparam int OUT_WIDTH = out_width(DATA_WIDTH, PACK_COUNT);
    localparam int PC_WIDTH  = pack_cnt_width(PACK_COUNT);

    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_underflow;
    logic                  flush;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_WIDTH-1:0]   pack_cnt;
    logic [CNT_WIDTH-1:0]  underflow_cnt;
`ifdef FIFO_DRAIN_PARITY_EN
    logic                  out_parity;
`endif

    // Drain packer side.
    modport master (
        output fifo_rd,
        input  fifo_data,
        input  fifo_underflow,
        input  flush,
        output out_data,
        output out_valid,
        input  out_ready,
        output pack_cnt,
        output underflow_cnt
`ifdef FIFO_DRAIN_PARITY_EN
        , output out_parity
`endif
    );

    // FIFO / downstream side.
    modport slave (
        input  fifo_rd,
        output fifo_data,
        output fifo_underflow,
        output flush,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  pack_cnt,
        input  underflow_cnt
`ifdef FIFO_DRAIN_PARITY_EN
        , input out_parity
`endif
    );

endinterface

// File: rtl/drain_backoff_timer.sv
// Down-counter that spaces retries after a failed pop; done marks the last idle cycle.
module drain_backoff_timer #(
    parameter int LOAD_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LOAD_WIDTH-1:0] load_val,
    input  logic                  en,
    output logic                  done
);

    logic [LOAD_WIDTH-1:0] count;

    // Load on a failed pop, otherwise count down while the FSM sits in BACKOFF.
    // NOTE: clocked state uses <= so every register samples pre-edge values; = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = en && (count == LOAD_WIDTH'(1));

endmodule

// File: rtl/fifo_drain_packer.sv
// Pops a FIFO one word per two cycles, packs PACK_COUNT words LSB-first,
// presents them on valid/ready. Optional macro FIFO_DRAIN_PARITY_EN adds out_parity.
module fifo_drain_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PACK_COUNT     = DEFAULT_PACK_COUNT,
    parameter int BACKOFF_CYCLES = 2,
    parameter int CNT_WIDTH      = 8
) (
    input logic                 clk,
    input logic                 rst,
    fifo_drain_packer_if.master bus
);

    localparam int OUT_WIDTH = out_width(DATA_WIDTH, PACK_COUNT);
    localparam int PC_WIDTH  = pack_cnt_width(PACK_COUNT);
    localparam int BO_WIDTH  = $clog2(BACKOFF_CYCLES + 1);

    drain_state_t         state, next_state;
    logic [PC_WIDTH-1:0]  pack_cnt;
    logic [OUT_WIDTH-1:0] pack_reg;
    logic [OUT_WIDTH-1:0] full_word;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic                 out_valid_q;
    logic [CNT_WIDTH-1:0] underflow_cnt;
    logic                 last_slot;
    logic                 word_ok;
    logic                 word_done;
    logic                 pop_failed;
    logic                 backoff_load;
    logic                 backoff_done;

    assign last_slot  = (pack_cnt == PC_WIDTH'(PACK_COUNT - 1));
    assign pop_failed = (state == CHECK) && bus.fifo_underflow;
    assign word_ok    = (state == CHECK) && !bus.fifo_underflow && !bus.flush;
    assign word_done  = word_ok && last_slot;

    drain_backoff_timer #(.LOAD_WIDTH(BO_WIDTH)) u_backoff (
        .clk      (clk),
        .rst      (rst),
        .load     (backoff_load),
        .load_val (BO_WIDTH'(BACKOFF_CYCLES)),
        .en       (state == BACKOFF),
        .done     (backoff_done)
    );

    // Merge the returning FIFO word into its slot of the partial pack.
    // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        full_word = pack_reg;
        for (int i = 0; i < PACK_COUNT; i++) begin
            if (pack_cnt == PC_WIDTH'(i)) begin
                full_word[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= POP;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and backoff timer control.
    always_comb begin
        next_state   = state;
        backoff_load = 1'b0;
        case (state)
            POP:     next_state = CHECK;
            CHECK: begin
                if (bus.fifo_underflow) begin
                    next_state   = BACKOFF;
                    backoff_load = 1'b1;
                end else if (bus.flush) begin
                    next_state = POP;
                end else if (last_slot) begin
                    next_state = HOLD;
                end else begin
                    next_state = POP;
                end
            end
            BACKOFF: if (backoff_done) next_state = POP;
            HOLD:    if (bus.out_ready) next_state = POP;
            default: next_state = POP;
        endcase
    end

    // Pack register, output word and saturating miss counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pack_cnt      <= '0;
            pack_reg      <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            if (word_done) begin
                out_data_q  <= full_word;
                out_valid_q <= 1'b1;
                pack_cnt    <= '0;
                pack_reg    <= '0;
            end else if (word_ok) begin
                pack_reg <= full_word;
                pack_cnt <= pack_cnt + 1'b1;
            end else if (bus.flush && state != HOLD) begin
                pack_cnt <= '0;
                pack_reg <= '0;
            end
            if (state == HOLD && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (pop_failed && underflow_cnt != '1) begin
                underflow_cnt <= underflow_cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_DRAIN_PARITY_EN
    logic out_parity_q;

    // Parity captured alongside the packed word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_parity_q <= 1'b0;
        end else if (word_done) begin
            out_parity_q <= ^full_word;
        end
    end

    assign bus.out_parity = out_parity_q;
`endif

    // Reset gates the pop so nothing is requested while rst is held low.
    assign bus.fifo_rd       = (state == POP) && rst;
    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.pack_cnt      = pack_cnt;
    assign bus.underflow_cnt = underflow_cnt;

endmodule
